// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   - fetch_state_e : FSM state encoding (IDLE/REQ/DROP/HOLD)
//   - INST_NOP      : instruction shown while no live instruction is held
//   - RESET_PC_DEFAULT : first fetch address after reset
//   - PC_INCR       : sequential PC step
//   - align_pc()    : clears the byte-offset bits of a fetch address
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] INST_NOP_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;

    // Fetch addresses are always word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_sva.sv
// Protocol checker for if_fetch_unit, instantiated alongside the design.
// Ports:
//   clk, rst_n        : clock and synchronous active-low reset
//   Icache_ready_i    : Icache response strobe
//   if_valid_req_o    : fetch unit has a request outstanding
// A response is only legal while a request is outstanding. The first cycle
// after reset release is excluded: a response for a request aborted by the
// reset may still arrive there and is simply ignored by the design.
module if_fetch_unit_sva (
    input logic clk,
    input logic rst_n,
    input logic Icache_ready_i,
    input logic if_valid_req_o
);

    logic first_after_reset;

    // Marks the first cycle after a reset edge.
    always_ff @(posedge clk) begin
        first_after_reset <= ~rst_n;
    end

    a_ready_only_when_requested: assert property (
        @(posedge clk) disable iff (!rst_n)
        (Icache_ready_i && !first_after_reset) |-> if_valid_req_o
    );

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. Owns the PC, keeps exactly one request
// outstanding to the Icache, drops responses overtaken by a redirect and
// presents fetched instructions to the IF/ID register.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   fc_jump_flag_i/pc_i    : redirect request and target from flow control
//   id_stall_i             : IF/ID cannot accept a new instruction
//   Icache_ready_i/inst_i  : response strobe and instruction word
//   if_req_addr_o          : fetch address (always the PC)
//   if_valid_req_o         : request outstanding
//   if_jump_stop_Icache_o  : the in-flight response will be discarded
//   if_inst_o/if_pc_o      : instruction and its PC to IF/ID
//   if_inst_valid_o        : if_inst_o/if_pc_o hold a live instruction
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] INST_NOP = INST_NOP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fc_jump_flag_i,
    input  logic [31:0] fc_jump_pc_i,
    input  logic        id_stall_i,
    input  logic        Icache_ready_i,
    input  logic [31:0] Icache_inst_i,
    output logic [31:0] if_req_addr_o,
    output logic        if_valid_req_o,
    output logic        if_jump_stop_Icache_o,
    output logic [31:0] if_inst_o,
    output logic [31:0] if_pc_o,
    output logic        if_inst_valid_o
);

    fetch_state_e state;
    logic [31:0]  pc;

    assign if_req_addr_o = pc;

    // Fetch FSM, PC and registered IF/ID outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                 <= ST_IDLE;
            pc                    <= align_pc(RESET_PC);
            if_valid_req_o        <= 1'b0;
            if_jump_stop_Icache_o <= 1'b0;
            if_inst_valid_o       <= 1'b0;
            if_inst_o             <= INST_NOP;
            if_pc_o               <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state          <= ST_REQ;
                    if_valid_req_o <= 1'b1;
                end

                ST_REQ: begin
                    if (Icache_ready_i && !fc_jump_flag_i) begin
                        if_inst_o       <= Icache_inst_i;
                        if_pc_o         <= pc;
                        if_inst_valid_o <= 1'b1;
                        pc              <= pc + PC_INCR;
                        if (id_stall_i) begin
                            state          <= ST_HOLD;
                            if_valid_req_o <= 1'b0;
                        end else begin
                            state <= ST_REQ;
                        end
                    end else if (fc_jump_flag_i) begin
                        // Redirect: a response arriving now is simply dropped;
                        // otherwise the old line must drain in DROP.
                        pc              <= align_pc(fc_jump_pc_i);
                        if_inst_valid_o <= 1'b0;
                        if_inst_o       <= INST_NOP;
                        if (Icache_ready_i) begin
                            state <= ST_REQ;
                        end else begin
                            state                 <= ST_DROP;
                            if_jump_stop_Icache_o <= 1'b1;
                        end
                    end else if (!id_stall_i) begin
                        // IF/ID took the presented instruction; nothing new yet.
                        if_inst_valid_o <= 1'b0;
                        if_inst_o       <= INST_NOP;
                    end else begin
                        state <= ST_REQ;
                    end
                end

                ST_DROP: begin
                    if (fc_jump_flag_i) begin
                        pc <= align_pc(fc_jump_pc_i);
                    end else begin
                        pc <= pc;
                    end
                    if (Icache_ready_i) begin
                        state                 <= ST_REQ;
                        if_jump_stop_Icache_o <= 1'b0;
                    end else begin
                        state <= ST_DROP;
                    end
                end

                ST_HOLD: begin
                    if (fc_jump_flag_i) begin
                        pc              <= align_pc(fc_jump_pc_i);
                        if_inst_valid_o <= 1'b0;
                        if_inst_o       <= INST_NOP;
                        state           <= ST_REQ;
                        if_valid_req_o  <= 1'b1;
                    end else if (!id_stall_i) begin
                        // Held instruction is consumed on this edge.
                        if_inst_valid_o <= 1'b0;
                        if_inst_o       <= INST_NOP;
                        state           <= ST_REQ;
                        if_valid_req_o  <= 1'b1;
                    end else begin
                        state <= ST_HOLD;
                    end
                end

                default: begin
                    state                 <= ST_IDLE;
                    if_valid_req_o        <= 1'b0;
                    if_jump_stop_Icache_o <= 1'b0;
                    if_inst_valid_o       <= 1'b0;
                    if_inst_o             <= INST_NOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by
// random traffic, compared against a transaction-level model. Every accepted
// fetch pushes {pc, inst} into a queue; a monitor pops it when the DUT
// presents a new instruction.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fc_jump_flag_i = 1'b0;
    logic [31:0] fc_jump_pc_i = 32'd0;
    logic        id_stall_i = 1'b0;
    logic        Icache_ready_i = 1'b0;
    logic [31:0] Icache_inst_i = 32'd0;
    logic [31:0] if_req_addr_o;
    logic        if_valid_req_o;
    logic        if_jump_stop_Icache_o;
    logic [31:0] if_inst_o;
    logic [31:0] if_pc_o;
    logic        if_inst_valid_o;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .fc_jump_flag_i        (fc_jump_flag_i),
        .fc_jump_pc_i          (fc_jump_pc_i),
        .id_stall_i            (id_stall_i),
        .Icache_ready_i        (Icache_ready_i),
        .Icache_inst_i         (Icache_inst_i),
        .if_req_addr_o         (if_req_addr_o),
        .if_valid_req_o        (if_valid_req_o),
        .if_jump_stop_Icache_o (if_jump_stop_Icache_o),
        .if_inst_o             (if_inst_o),
        .if_pc_o               (if_pc_o),
        .if_inst_valid_o       (if_inst_valid_o)
    );

    if_fetch_unit_sva chk (
        .clk            (clk),
        .rst_n          (rst_n),
        .Icache_ready_i (Icache_ready_i),
        .if_valid_req_o (if_valid_req_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what the fetch unit is doing, in spec terms.
    typedef enum int {M_IDLE, M_FETCH, M_DROP, M_HOLD} mode_e;
    mode_e       m_mode  = M_IDLE;
    logic [31:0] m_pc    = RST_PC;
    logic        m_valid = 1'b0;
    logic [31:0] m_inst  = NOP;
    logic [31:0] m_pcout = 32'd0;
    bit          model_ok = 1'b0;
    logic [63:0] exp_q[$];

    function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void redirect();
        m_pc    = fc_jump_pc_i & 32'hFFFF_FFFC;
        m_valid = 1'b0;
        m_inst  = NOP;
    endfunction

    // Advance the model across the clock edge just taken, using held inputs.
    function automatic void model_step();
        if (!rst_n) begin
            m_mode = M_IDLE; m_pc = RST_PC; m_valid = 1'b0;
            m_inst = NOP; m_pcout = 32'd0;
            exp_q.delete();
        end else begin
            case (m_mode)
                M_IDLE: m_mode = M_FETCH;
                M_FETCH: begin
                    if (Icache_ready_i && !fc_jump_flag_i) begin
                        exp_q.push_back({m_pc, Icache_inst_i});
                        m_valid = 1'b1; m_inst = Icache_inst_i; m_pcout = m_pc;
                        m_pc = m_pc + 32'd4;
                        if (id_stall_i) m_mode = M_HOLD;
                    end else if (fc_jump_flag_i) begin
                        redirect();
                        if (!Icache_ready_i) m_mode = M_DROP;
                    end else if (!id_stall_i) begin
                        m_valid = 1'b0; m_inst = NOP;
                    end
                end
                M_DROP: begin
                    if (fc_jump_flag_i) m_pc = fc_jump_pc_i & 32'hFFFF_FFFC;
                    if (Icache_ready_i) m_mode = M_FETCH;
                end
                M_HOLD: begin
                    if (fc_jump_flag_i) begin
                        redirect(); m_mode = M_FETCH;
                    end else if (!id_stall_i) begin
                        m_valid = 1'b0; m_inst = NOP; m_mode = M_FETCH;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
        model_ok = 1'b1;
    endfunction

    // Drive one cycle of inputs, take the edge, update the model.
    task automatic cyc(input logic r, input logic j, input logic [31:0] t,
                       input logic s, input logic rd, input logic [31:0] ins);
        rst_n = r; fc_jump_flag_i = j; fc_jump_pc_i = t;
        id_stall_i = s; Icache_ready_i = rd; Icache_inst_i = ins;
        @(posedge clk);
        #1;
        model_step();
    endtask

    // Monitor: status every cycle, scoreboard pop on each new instruction.
    initial begin
        logic        pv;
        logic [31:0] ppc;
        logic [63:0] e;
        pv = 1'b0; ppc = 32'd0;
        forever begin
            @(negedge clk);
            if (model_ok) begin
                check32("valid_req", {31'd0, if_valid_req_o},
                        {31'd0, (m_mode == M_FETCH || m_mode == M_DROP)});
                check32("jump_stop", {31'd0, if_jump_stop_Icache_o}, {31'd0, (m_mode == M_DROP)});
                check32("req_addr", if_req_addr_o, m_pc);
                check32("inst_valid", {31'd0, if_inst_valid_o}, {31'd0, m_valid});
                if (!if_inst_valid_o) begin
                    check32("nop_when_invalid", if_inst_o, NOP);
                end else begin
                    check32("held_pc", if_pc_o, m_pcout);
                    check32("held_inst", if_inst_o, m_inst);
                    if (!pv || if_pc_o != ppc) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++; n_bad++;
                            $display("FAIL unexpected_output: pc %h inst %h, no fetch expected", if_pc_o, if_inst_o);
                        end else begin
                            e = exp_q.pop_front();
                            check32("out_pc", if_pc_o, e[63:32]);
                            check32("out_inst", if_inst_o, e[31:0]);
                        end
                    end
                end
                pv = if_inst_valid_o; ppc = if_pc_o;
            end
        end
    end

    initial begin
        // Reset, then zero-wait hits at 0,4,8,C.
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, $urandom);
        // Request at 0x10 with three wait cycles.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'hA000_0010);
        // Hits up to 0x20, then jump to 0x103 while 0x20 is pending.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, $urandom);
        cyc(1'b1, 1'b1, 32'h0000_0103, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'hDEAD_0020);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'hB000_0100);
        // Jump and ready together: to 0x40, then 0x40 -> 0x80.
        cyc(1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'hDEAD_0104);
        cyc(1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b1, 32'hDEAD_0040);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'hC000_0080);
        // Output at 0x8 held by a 4-cycle stall, then resume at 0xC.
        cyc(1'b1, 1'b1, 32'h0000_0008, 1'b0, 1'b1, 32'hDEAD_0084);
        cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'hD000_0008);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'hD000_000C);
        // Enter HOLD again, then a jump during HOLD.
        cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'hD000_0010);
        cyc(1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'd0);
        // PC wrap at the top of the address space.
        cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hDEAD_0200);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'hE000_FFFC);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'hE000_0000);
        // Reset mid-DROP, stale ready right after release, then fetch at 0.
        cyc(1'b1, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'hDEAD_0300);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'hF000_0000);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        r, j, s, rd;
            logic [31:0] t;
            r  = ($urandom_range(0, 199) != 0);
            j  = ($urandom_range(0, 7) == 0);
            s  = ($urandom_range(0, 2) == 0);
            rd = (m_mode == M_FETCH || m_mode == M_DROP) && ($urandom_range(0, 2) != 0);
            t  = $urandom;
            if ($urandom_range(0, 3) == 0) t = {20'd0, t[11:0]};
            cyc(r, j, t, s, rd, $urandom);
        end
        // Drain, then nothing may be left unpresented.
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        #1;
        check32("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of the flow-control unit and the IF/ID register. It owns the PC and issues one outstanding request at a time to the Icache. It consumes the resolved jump/branch redirect and discards any in-flight fetch overtaken by that redirect. It presents a fetched instruction and its PC to the IF/ID register and reports request and jump-discard status back to flow control.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
INST_NOP, 32'h0000_0013, instruction presented whenever if_inst_valid_o=0

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous reset, active-low
fc_jump_flag_i  in  1  redirect request from flow control
fc_jump_pc_i  in  32  redirect target
id_stall_i  in  1  IF/ID cannot accept a new instruction this cycle
Icache_ready_i  in  1  response valid for the outstanding request
Icache_inst_i  in  32  response instruction word
if_req_addr_o  out  32  fetch address, word aligned
if_valid_req_o  out  1  request outstanding, to Icache and flow control
if_jump_stop_Icache_o  out  1  in-flight response is to be discarded
if_inst_o  out  32  instruction to IF/ID
if_pc_o  out  32  PC of if_inst_o
if_inst_valid_o  out  1  if_inst_o/if_pc_o hold a live instruction

Behaviour:
- Reset: applied on the clk edge while rst_n=0; asserting it mid-operation aborts everything, and any later Icache response is ignored until a new request is issued. Reset values: pc=RESET_PC, state=IDLE, if_valid_req_o=0, if_jump_stop_Icache_o=0, if_inst_valid_o=0, if_inst_o=INST_NOP, if_pc_o=0, if_req_addr_o=RESET_PC.
- if_req_addr_o always equals pc; pc[1:0] is forced to 0 on every load. pc+4 wraps 32'hFFFF_FFFC -> 0.
- FSM states: IDLE, REQ, DROP, HOLD.
- IDLE: moves to REQ unconditionally on the next edge after reset release.
- REQ:
  - if_valid_req_o=1. Address is held stable until Icache_ready_i=1.
  - Icache_ready_i=1 is legal in the first REQ cycle (zero-wait hit).
  - ready=1, jump=0: capture if_inst_o<=Icache_inst_i, if_pc_o<=pc, if_inst_valid_o<=1, pc<=pc+4. Go to HOLD if id_stall_i=1, else stay in REQ. Output latency is 1 cycle after the ready edge.
  - ready=1, jump=1: discard the data, pc<=fc_jump_pc_i, if_inst_valid_o<=0, stay in REQ.
  - ready=0, jump=1: pc<=fc_jump_pc_i, if_inst_valid_o<=0, go to DROP.
- DROP:
  - if_valid_req_o=1 and if_jump_stop_Icache_o=1. The address shown is the new target; the Icache finishes the old line.
  - Icache_ready_i=1: discard the response, go to REQ.
  - A further jump in DROP: pc<=new target, stay in DROP, or go to REQ if ready=1 in the same cycle.
- HOLD:
  - if_valid_req_o=0. Outputs are frozen.
  - id_stall_i=0: go to REQ. if_inst_valid_o stays 1 for the cycle of that edge; IF/ID consumes it.
  - jump=1 has priority over the stall: if_inst_valid_o<=0, pc<=target, go to REQ.
- In REQ with id_stall_i=1 and no response pending, outputs are held.
- Any redirect clears if_inst_valid_o on the next edge. if_inst_o returns to INST_NOP whenever valid=0.
- Icache_ready_i in IDLE or HOLD is ignored. If it occurs outside reset it is flagged by an assertion.
- Only one request is ever outstanding. No prefetch.

Decomposition:
- Shared package: FSM state encoding (2-bit localparams IDLE/REQ/DROP/HOLD), INST_NOP, RESET_PC default, and the PC increment constant 4.
- Single module. The PC/next-PC mux and the output register are small enough to stay inline; no sub-module is needed.

Test Plan:
- Reset release, zero-wait hits every cycle, id_stall_i=0 -> if_pc_o sequence 0,4,8,... with a 1-cycle latency after each ready; valid stays continuously 1.
- Request at pc 0x10, ready delayed 3 cycles -> if_req_addr_o held at 0x10 throughout; if_inst_valid_o=1 only after ready.
- Jump to 0x103 while request at 0x20 pending -> pc 0x100, DROP entered, if_jump_stop_Icache_o=1 until ready; old data not presented; next output pc 0x100.
- Jump and ready in the same cycle at pc 0x40, target 0x80 -> no output for 0x40; next request at 0x80.
- Output at 0x8 with id_stall_i=1 for 4 cycles -> outputs frozen and if_valid_req_o=0; on release the fetch of 0xC resumes. A jump during HOLD -> valid=0 next cycle.
- rst_n low for 1 cycle mid-DROP -> all outputs at reset values; a stale ready the next cycle is ignored; the first output is RESET_PC.
